// File: rtl/enc_pkg.sv
// Shared types and constants for the 7-bit LFSR text encryption sequencer.
// The tap table is a reference copy; the hardware reads taps from data memory.
package enc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_PRE,
        LD_PT,
        LD_TAP,
        LD_INIT,
        RD,
        WR,
        DONE
    } state_t;

    localparam logic [7:0] PRE_ADDR  = 8'd61;
    localparam logic [7:0] PT_ADDR   = 8'd62;
    localparam logic [7:0] INIT_ADDR = 8'd63;
    localparam logic [7:0] PRE_MIN   = 8'd10;
    localparam logic [7:0] PRE_MAX   = 8'd26;
    localparam int         NCHAR     = 64;

    localparam logic [6:0] TAP_TABLE [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                             7'h69, 7'h5C, 7'h7E, 7'h7B};

    // Padding length saturates into [PRE_MIN, PRE_MAX]; the result fits in 5 bits.
    function automatic logic [4:0] clamp_pre(input logic [7:0] v);
        logic [7:0] c;
        c = v;
        if (v < PRE_MIN) c = PRE_MIN;
        if (v > PRE_MAX) c = PRE_MAX;
        return c[4:0];
    endfunction

endpackage

// File: rtl/encrypt_lfsr7.sv
// One combinational step of the 7-bit Fibonacci LFSR; parity is the feedback bit.
module encrypt_lfsr7 (
    input  logic [6:0] state,
    input  logic [6:0] taps,
    output logic [6:0] next_state,
    output logic       parity
);

    assign parity     = ^(state & taps);
    assign next_state = {state[5:0], parity};

endmodule

// File: rtl/encrypt_sequencer.sv
// Reads setup words and plaintext from data memory, writes 64 LFSR-encrypted
// characters (leading space padding) starting at OUT_BASE, then reports Ack.
module encrypt_sequencer
    import enc_pkg::*;
#(
    parameter logic [7:0] OUT_BASE = 8'd64,
    parameter logic [7:0] TAP_BASE = 8'd128
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic [7:0] MemAddr,
    output logic       MemWrEn,
    output logic [7:0] MemWData,
    input  logic [7:0] MemRData
);

    state_t      state_reg;
    state_t      state_next;
    logic        start_reg;
    logic [4:0]  pre_reg;
    logic [3:0]  sel_reg;
    logic [6:0]  taps_reg;
    logic [6:0]  lfsr_reg;
    logic [5:0]  idx_reg;
    logic [6:0]  ch_reg;

    logic [6:0]  lfsr_next;
    logic        lfsr_fb;
    logic [6:0]  cipher;
    logic        in_pad;

    encrypt_lfsr7 u_lfsr (
        .state      (lfsr_reg),
        .taps       (taps_reg),
        .next_state (lfsr_next),
        .parity     (lfsr_fb)
    );

    assign cipher = ch_reg ^ lfsr_reg;
    assign in_pad = ({1'b0, idx_reg} < {2'b00, pre_reg});

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_reg && !Start) state_next = LD_PRE;
            LD_PRE:  state_next = LD_PT;
            LD_PT:   state_next = LD_TAP;
            LD_TAP:  state_next = LD_INIT;
            LD_INIT: state_next = RD;
            RD:      state_next = WR;
            WR:      state_next = (idx_reg == 6'(NCHAR - 1)) ? DONE : RD;
            DONE:    if (Start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Ack      = 1'b0;
        MemAddr  = 8'd0;
        MemWrEn  = 1'b0;
        MemWData = 8'd0;
        case (state_reg)
            LD_PRE:  MemAddr = PRE_ADDR;
            LD_PT:   MemAddr = PT_ADDR;
            LD_TAP:  MemAddr = TAP_BASE + {4'd0, sel_reg};
            LD_INIT: MemAddr = INIT_ADDR;
            RD:      MemAddr = in_pad ? 8'd0 : ({2'b00, idx_reg} - {3'b000, pre_reg});
            WR: begin
                MemAddr  = OUT_BASE + {2'b00, idx_reg};
                MemWrEn  = 1'b1;
                MemWData = {^cipher, cipher};
            end
            DONE:    Ack = 1'b1;
            default: ;
        endcase
    end

    // Start is sampled every cycle so DONE->IDLE arrives with a primed edge detector.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            start_reg <= 1'b1;
            pre_reg   <= 5'd0;
            sel_reg   <= 4'd0;
            taps_reg  <= 7'd0;
            lfsr_reg  <= 7'd0;
            idx_reg   <= 6'd0;
            ch_reg    <= 7'd0;
        end else begin
            start_reg <= Start;
            case (state_reg)
                IDLE:    idx_reg <= 6'd0;
                LD_PRE:  pre_reg <= clamp_pre(MemRData);
                LD_PT:   sel_reg <= (MemRData == 8'd8) ? 4'd8 : {1'b0, MemRData[2:0]};
                LD_TAP:  taps_reg <= MemRData[6:0];
                LD_INIT: lfsr_reg <= (MemRData[6:0] == 7'd0) ? 7'h01 : MemRData[6:0];
                RD:      ch_reg <= in_pad ? 7'h20 : MemRData[6:0];
                WR: begin
                    lfsr_reg <= lfsr_next;
                    idx_reg  <= idx_reg + 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt_sequencer.sv
// Scoreboard bench: a plain-arithmetic encryption model queues expected writes,
// a monitor pops and compares each write the sequencer makes.
module tb_encrypt_sequencer;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       Ack;
    logic [7:0] MemAddr;
    logic       MemWrEn;
    logic [7:0] MemWData;
    logic [7:0] MemRData;

    logic [7:0] dm [256];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t sb [$];
    int  checks;
    int  errors;
    int  wr_count;
    int  tap_ref [9] = '{'h60, 'h48, 'h78, 'h72, 'h6A, 'h69, 'h5C, 'h7E, 'h7B};

    encrypt_sequencer #(.OUT_BASE(8'd64), .TAP_BASE(8'd128)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Ack      (Ack),
        .MemAddr  (MemAddr),
        .MemWrEn  (MemWrEn),
        .MemWData (MemWData),
        .MemRData (MemRData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign MemRData = dm[MemAddr];

    always @(posedge Clk) begin
        if (Reset && MemWrEn) dm[MemAddr] = MemWData;
    end

    // Monitor: every write the DUT presents must match the head of the scoreboard.
    always @(negedge Clk) begin
        if (Reset && MemWrEn) begin
            wr_t e;
            wr_count = wr_count + 1;
            checks = checks + 1;
            if (MemAddr < 8'd64) begin
                errors = errors + 1;
                $display("FAIL wr_below_out addr=%0d required>=64", MemAddr);
            end
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_write addr=%0d data=%02h required=no write", MemAddr, MemWData);
            end else begin
                e = sb.pop_front();
                if (MemAddr !== e.addr || MemWData !== e.data) begin
                    errors = errors + 1;
                    $display("FAIL write addr=%0d data=%02h required addr=%0d data=%02h",
                             MemAddr, MemWData, e.addr, e.data);
                end else begin
                    $display("write addr=%0d data=%02h ok", MemAddr, MemWData);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Fill memory: plaintext, setup words, tap table; clear output area.
    task automatic setup(input int pre_v, input int pt_v, input int init_v, input int d0);
        for (int a = 0; a < 61; a++) dm[a] = 8'($urandom_range(0, 255));
        if (d0 >= 0) dm[0] = 8'(d0);
        dm[61] = 8'(pre_v);
        dm[62] = 8'(pt_v);
        dm[63] = 8'(init_v);
        for (int a = 64; a < 128; a++) dm[a] = 8'h00;
        for (int k = 0; k < 9; k++) dm[128 + k] = 8'(tap_ref[k]);
        for (int a = 137; a < 256; a++) dm[a] = 8'h00;
    endtask

    // Reference model: padding spaces, then plaintext, each XORed with the LFSR
    // state; the output byte carries even parity of the 7-bit cipher in bit 7.
    task automatic build_expected();
        int pre, sel, taps, lfsr, ch, x, d, fb;
        pre = dm[61];
        if (pre < 10) pre = 10;
        if (pre > 26) pre = 26;
        sel  = (dm[62] == 8) ? 8 : dm[62] % 8;
        taps = tap_ref[sel];
        lfsr = dm[63] % 128;
        if (lfsr == 0) lfsr = 1;
        for (int i = 0; i < 64; i++) begin
            ch = (i < pre) ? 32 : dm[i - pre];
            x  = (ch ^ lfsr) % 128;
            d  = x + (($countones(x) % 2) * 128);
            sb.push_back('{addr: 8'(64 + i), data: 8'(d)});
            fb   = $countones(lfsr & taps) % 2;
            lfsr = ((lfsr * 2) % 128) + fb;
        end
    endtask

    task automatic do_run(input string name, input bit toggle, input bit hold_low);
        int n;
        int w0;
        build_expected();
        wr_count = 0;
        @(negedge Clk);
        Start = 1'b0;
        @(posedge Clk);
        n = 0;
        while (!Ack && n < 300) begin
            @(posedge Clk);
            #1;
            n++;
            if (toggle) Start = (n < 125) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        $display("run %s ack_after=%0d writes=%0d", name, n, wr_count);
        check({name, "_ack_latency"}, n, 132);
        check({name, "_write_count"}, wr_count, 64);
        check({name, "_sb_empty"}, sb.size(), 0);
        if (hold_low) begin
            w0 = wr_count;
            repeat (20) @(posedge Clk);
            #1;
            check({name, "_hold_ack"}, int'(Ack), 1);
            check({name, "_hold_no_writes"}, wr_count, w0);
        end
        @(negedge Clk);
        Start = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check({name, "_idle_ack"}, int'(Ack), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        wr_count = 0;
        Start    = 1'b1;
        Reset    = 1'b0;
        setup(20, 0, 5, -1);
        repeat (3) @(posedge Clk);
        #1;
        check("rst_ack", int'(Ack), 0);
        check("rst_wren", int'(MemWrEn), 0);
        check("rst_addr", int'(MemAddr), 0);
        check("rst_wdata", int'(MemWData), 0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("idle_addr", int'(MemAddr), 0);
        check("idle_wdata", int'(MemWData), 0);

        setup(29, 8, 31, -1);
        do_run("clamp_hi", 1'b0, 1'b0);
        check("clamp_hi_dm64", int'(dm[64]), 'h3F);
        check("clamp_hi_dm65", int'(dm[65]), 'h1E);

        setup(10, 3, 0, -1);
        do_run("init_zero", 1'b0, 1'b0);
        check("init_zero_dm64", int'(dm[64]), 'h21);

        setup(15, 13, 99, -1);
        do_run("pt13", 1'b0, 1'b0);

        setup(5, 2, 77, 'h4D);
        do_run("pre_low_M", 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            setup($urandom_range(0, 40), $urandom_range(0, 15), $urandom_range(0, 127), -1);
            do_run($sformatf("rand%0d", r), r[0], 1'b0);
        end

        // Abandon a run mid-way with reset, then relaunch.
        setup(12, 6, 44, -1);
        build_expected();
        @(negedge Clk);
        Start = 1'b0;
        @(posedge Clk);
        repeat (50) @(posedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        check("midrst_wren", int'(MemWrEn), 0);
        check("midrst_ack", int'(Ack), 0);
        check("midrst_addr", int'(MemAddr), 0);
        sb.delete();
        Start = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("midrst_held_wren", int'(MemWrEn), 0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        setup(12, 6, 44, -1);
        do_run("relaunch", 1'b0, 1'b0);

        // Start held low after DONE must not relaunch; a fresh edge repeats the run.
        setup(18, 4, 60, -1);
        do_run("hold_low", 1'b0, 1'b1);
        do_run("second", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encrypt_sequencer.md
ENCRYPT_SEQUENCER -- requirements
Module: encrypt_sequencer

Interface
REQ-001 Parameter: OUT_BASE, 64, first data-memory address of encrypted output.
REQ-002 Parameter: TAP_BASE, 128, first data-memory address of the 9-entry LFSR tap-pattern table.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Start  input  1  high holds the block idle; a 1-to-0 transition launches one encryption run.
REQ-006 Ack  output  1  high while a completed run is reported (state DONE).
REQ-007 MemAddr  output  8  data-memory address.
REQ-008 MemWrEn  output  1  write strobe, one cycle per write.
REQ-009 MemWData  output  8  write data.
REQ-010 MemRData  input  8  read data; combinational read, valid in the same cycle as MemAddr.

Function
REQ-011 The FSM SHALL use states IDLE, LD_PRE, LD_PT, LD_TAP, LD_INIT, RD, WR, DONE.
REQ-012 IDLE SHALL register Start each cycle and go to LD_PRE when registered Start=1 and current Start=0.
REQ-013 LD_PRE SHALL read address 61 and clamp it: <10 -> 10, >26 -> 26, else unchanged.
REQ-014 LD_PT SHALL read address 62 into sel: value 8 -> 8, any other value -> bits [2:0].
REQ-015 LD_TAP SHALL read TAP_BASE+sel and keep bits [6:0] as taps.
REQ-016 LD_INIT SHALL read address 63 into lfsr[6:0]; value 0 SHALL load 7'h01.
REQ-017 The character index i SHALL start at 0 and cover 0..63; each index SHALL take exactly one RD and one WR cycle.
REQ-018 RD SHALL set ch = 8'h20 when i < pre; otherwise it SHALL read address i-pre into ch.
REQ-019 WR SHALL write address OUT_BASE+i with data {^x[6:0], x[6:0]}, where x = ch ^ {1'b0, lfsr}.
REQ-020 WR SHALL also update lfsr to {lfsr[5:0], ^(lfsr & taps)} and increment i.
REQ-021 After WR with i=63, the FSM SHALL enter DONE; otherwise it SHALL return to RD.
REQ-022 DONE SHALL hold Ack=1 until Start=1 is sampled, then return to IDLE with Ack=0.
REQ-023 Timing: Ack SHALL rise exactly 132 rising edges after the edge that leaves IDLE, independent of pre.
REQ-024 MemWrEn SHALL be 1 only in WR; the block SHALL make exactly 64 writes per run and none to addresses below OUT_BASE.
REQ-025 Start changes during LD_*/RD/WR SHALL be ignored; the run SHALL complete.
REQ-026 A run SHALL launch only from IDLE; a continuously low Start SHALL NOT relaunch after DONE.
REQ-027 When idle, MemAddr and MemWData SHALL be 0.

Reset
REQ-028 Reset=0 SHALL immediately force IDLE, with Ack=0, MemWrEn=0, MemAddr=0, MemWData=0, i=0, lfsr=0, taps=0, pre=0, and registered Start=1.
REQ-029 A reset mid-run SHALL abandon the run with no further writes; the next launch SHALL execute a complete, correct run.

Structure
REQ-030 Shared package enc_pkg SHALL hold:
- the state enum;
- address constants PRE_ADDR=61, PT_ADDR=62, INIT_ADDR=63;
- PRE_MIN=10, PRE_MAX=26, NCHAR=64;
- the 9 tap values 7'h60, 48, 78, 72, 6A, 69, 5C, 7E, 7B, for bench reference only.
REQ-031 The LFSR step and parity SHALL be one combinational sub-module, encrypt_lfsr7 (inputs state and taps; outputs next state and parity).

Verification
REQ-032 pt_no=8 (taps 7'h7B), init=31, DM[61]=29 -> pre clamps to 26; DM[64]=0x3F, DM[65]=0x1E; DM[64..89] are all padding-space ciphertext.
REQ-033 DM[63]=0, pre=10 -> lfsr loads 1; DM[64]=0x21.
REQ-034 DM[62]=13 -> tap read at address 133 (taps 7'h69); all 64 outputs match the bench model.
REQ-035 DM[61]=5 -> pre=10; DM[0]='M' (0x4D) encrypts into DM[74]; Ack rises 132 edges after launch.
REQ-036 Reset pulled low at cycle 50 of a run -> MemWrEn=0 and Ack=0 immediately; a relaunch scores 64/64.
REQ-037 Start held low after DONE -> no second run and Ack stays high; Start high then low -> a second identical run.
